nios2_ocimem_arbiter: RTL and testbench

Sequences debug-memory accesses requested by the JTAG debug slave's system-clock half and shares the single-port on-chip debug RAM (OCI RAM) with the CPU's Avalon debug-memory port. JTAG commands arrive as one-cycle `take_action_ocimem_*` pulses with payload on `jdo`. The arbiter drives `MonDReg`, `monitor_ready` and `monitor_error` back to the debug slave for shift-out.

---
 rtl/nios2_ocimem_arbiter.sv | 235 +++++++++++++++++++++++
 tb/tb_nios2_ocimem_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_ocimem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : nios2_ocimem_arbiter
// Description : Shares the single-port on-chip debug RAM (OCI RAM) between
//               JTAG debug-slave commands and the CPU's Avalon debug-memory
//               port. JTAG commands are held in a one-deep pending slot.
//               When both sides want the RAM at once, the side that was not
//               served last goes first (round robin).
// Ports       : clk, reset_n               - clock, async active-low reset
//               take_action_ocimem_a/_b    - JTAG command / write pulses
//               jdo[37:0]                  - JTAG payload
//               debugack                   - CPU in debug mode (gates writes)
//               cpu_*                      - Avalon-MM slave request/response
//               ram_*                      - OCI RAM port (1-cycle read)
//               MonDReg, monitor_ready,
//               monitor_error              - status back to the debug slave
// Revision    : 1.0 - initial release
// ============================================================================
module nios2_ocimem_arbiter #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [37:0]       jdo,
  input  logic              debugack,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [31:0]       cpu_writedata,
  input  logic [3:0]        cpu_byteenable,
  output logic [31:0]       cpu_readdata,
  output logic              cpu_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [31:0]       ram_wdata,
  output logic [3:0]        ram_byteen,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_J_RD = 2'd1,
    ST_C_RD = 2'd2
  } state_t;

  localparam logic GRANT_CPU  = 1'b0;
  localparam logic GRANT_JTAG = 1'b1;

  localparam logic [1:0] CMD_LOAD_ADDR = 2'b00;
  localparam logic [1:0] CMD_READ_INCR = 2'b01;
  localparam logic [1:0] CMD_READ_HOLD = 2'b10;
  localparam logic [1:0] CMD_CLR_ERR   = 2'b11;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   jaddr_q, jaddr_d;
  logic                slot_valid_q, slot_valid_d;
  logic                slot_wr_q, slot_wr_d;
  logic                slot_incr_q, slot_incr_d;
  logic [31:0]         slot_data_q, slot_data_d;
  logic                last_grant_q, last_grant_d;
  logic [31:0]         mon_dreg_q, mon_dreg_d;
  logic                mon_ready_q, mon_ready_d;
  logic                mon_error_q, mon_error_d;
  // Cleared asynchronously by reset and set on the first clock afterwards.
  // No grant (and hence no RAM write) can happen while it is low.
  logic                run_q;

  logic                jtag_req;
  logic                cpu_req;
  logic                wr_grant;
  logic                cpu_wr_done;
  logic                cmd_err;
  logic                cmd_clr;
  logic [1:0]          cmd;

  // Payload bits between the command field and the data word carry nothing.
  logic                unused_jdo;
  assign unused_jdo = ^jdo[35:32];

  assign cmd      = jdo[37:36];
  assign jtag_req = slot_valid_q;
  assign cpu_req  = cpu_read | cpu_write;

  always_comb begin
    state_d      = state_q;
    jaddr_d      = jaddr_q;
    slot_valid_d = slot_valid_q;
    slot_wr_d    = slot_wr_q;
    slot_incr_d  = slot_incr_q;
    slot_data_d  = slot_data_q;
    last_grant_d = last_grant_q;
    mon_dreg_d   = mon_dreg_q;
    mon_ready_d  = mon_ready_q;
    mon_error_d  = mon_error_q;
    ram_addr     = jaddr_q;
    ram_wdata    = slot_data_q;
    ram_byteen   = 4'hF;
    wr_grant     = 1'b0;
    cpu_wr_done  = 1'b0;
    cmd_err      = 1'b0;
    cmd_clr      = 1'b0;

    // ---------------- arbitration / RAM sequencing ----------------
    case (state_q)
      ST_IDLE: begin
        if (run_q && jtag_req && (!cpu_req || last_grant_q == GRANT_CPU)) begin
          last_grant_d = GRANT_JTAG;
          ram_addr     = jaddr_q;
          if (slot_incr_q) begin
            jaddr_d = jaddr_q + ADDR_W'(1);
          end
          if (slot_wr_q) begin
            wr_grant     = 1'b1;
            ram_wdata    = slot_data_q;
            ram_byteen   = 4'hF;
            slot_valid_d = 1'b0;
            mon_ready_d  = 1'b1;
          end else begin
            state_d = ST_J_RD;
          end
        end else if (run_q && cpu_req) begin
          last_grant_d = GRANT_CPU;
          ram_addr     = cpu_address;
          if (cpu_write) begin
            wr_grant    = 1'b1;
            cpu_wr_done = 1'b1;
            ram_wdata   = cpu_writedata;
            ram_byteen  = cpu_byteenable;
          end else begin
            state_d = ST_C_RD;
          end
        end
      end
      ST_J_RD: begin
        mon_dreg_d   = ram_rdata;
        slot_valid_d = 1'b0;
        mon_ready_d  = 1'b1;
        state_d      = ST_IDLE;
      end
      ST_C_RD: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // ---------------- JTAG command decode ----------------
    // A slot fill only happens when the slot is empty, and the arbiter only
    // touches the slot when it is full, so the two halves never collide.
    if (take_action_ocimem_a) begin
      if (slot_valid_q) begin
        cmd_err = 1'b1;
      end else begin
        case (cmd)
          CMD_LOAD_ADDR: jaddr_d = jdo[ADDR_W-1:0];
          CMD_CLR_ERR:   cmd_clr = 1'b1;
          CMD_READ_INCR, CMD_READ_HOLD: begin
            slot_valid_d = 1'b1;
            slot_wr_d    = 1'b0;
            slot_incr_d  = (cmd == CMD_READ_INCR);
            mon_ready_d  = 1'b0;
          end
          default: cmd_err = 1'b0;
        endcase
      end
      // A write pulse colliding with a command pulse loses.
      if (take_action_ocimem_b) begin
        cmd_err = 1'b1;
      end
    end else if (take_action_ocimem_b) begin
      if (slot_valid_q || !debugack) begin
        cmd_err = 1'b1;
      end else begin
        slot_valid_d = 1'b1;
        slot_wr_d    = 1'b1;
        slot_incr_d  = 1'b1;
        slot_data_d  = jdo[31:0];
        mon_ready_d  = 1'b0;
      end
    end

    // A fresh error in the same cycle as a clear must survive.
    if (cmd_clr) begin
      mon_error_d = 1'b0;
    end
    if (cmd_err) begin
      mon_error_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      jaddr_q      <= '0;
      slot_valid_q <= 1'b0;
      slot_wr_q    <= 1'b0;
      slot_incr_q  <= 1'b0;
      slot_data_q  <= 32'h0;
      last_grant_q <= GRANT_CPU;
      mon_dreg_q   <= 32'h0;
      mon_ready_q  <= 1'b1;
      mon_error_q  <= 1'b0;
      run_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      jaddr_q      <= jaddr_d;
      slot_valid_q <= slot_valid_d;
      slot_wr_q    <= slot_wr_d;
      slot_incr_q  <= slot_incr_d;
      slot_data_q  <= slot_data_d;
      last_grant_q <= last_grant_d;
      mon_dreg_q   <= mon_dreg_d;
      mon_ready_q  <= mon_ready_d;
      mon_error_q  <= mon_error_d;
      run_q        <= 1'b1;
    end
  end

  // Read data is only presented in the cycle the RAM returns it for the CPU.
  assign cpu_readdata    = (state_q == ST_C_RD) ? ram_rdata : 32'h0;
  assign cpu_waitrequest = cpu_req & ~(cpu_wr_done | (state_q == ST_C_RD));
  assign ram_wren        = wr_grant;

  assign MonDReg       = mon_dreg_q;
  assign monitor_ready = mon_ready_q;
  assign monitor_error = mon_error_q;

endmodule
`default_nettype wire

// File: tb/tb_nios2_ocimem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_nios2_ocimem_arbiter
// Description : Self-checking bench for nios2_ocimem_arbiter with a
//               registered RAM model, a JTAG vector table and hand-written
//               arbitration / reset sequences. Expected read data is queued
//               when stimulus is driven and compared on completion.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nios2_ocimem_arbiter;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              take_action_ocimem_a;
  logic              take_action_ocimem_b;
  logic [37:0]       jdo;
  logic              debugack;
  logic [ADDR_W-1:0] cpu_address;
  logic              cpu_read;
  logic              cpu_write;
  logic [31:0]       cpu_writedata;
  logic [3:0]        cpu_byteenable;
  logic [31:0]       cpu_readdata;
  logic              cpu_waitrequest;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wren;
  logic [31:0]       ram_wdata;
  logic [3:0]        ram_byteen;
  logic [31:0]       ram_rdata;
  logic [31:0]       MonDReg;
  logic              monitor_ready;
  logic              monitor_error;

  always #5 clk = ~clk;

  nios2_ocimem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .take_action_ocimem_a (take_action_ocimem_a),
    .take_action_ocimem_b (take_action_ocimem_b),
    .jdo                  (jdo),
    .debugack             (debugack),
    .cpu_address          (cpu_address),
    .cpu_read             (cpu_read),
    .cpu_write            (cpu_write),
    .cpu_writedata        (cpu_writedata),
    .cpu_byteenable       (cpu_byteenable),
    .cpu_readdata         (cpu_readdata),
    .cpu_waitrequest      (cpu_waitrequest),
    .ram_addr             (ram_addr),
    .ram_wren             (ram_wren),
    .ram_wdata            (ram_wdata),
    .ram_byteen           (ram_byteen),
    .ram_rdata            (ram_rdata),
    .MonDReg              (MonDReg),
    .monitor_ready        (monitor_ready),
    .monitor_error        (monitor_error)
  );

  // Registered single-port RAM model, one-cycle read latency.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (ram_wren) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_byteen[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
      end
    end
    ram_rdata <= mem[ram_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { bit chk; logic [31:0] d; } sb_t;
  sb_t         jq[$];
  logic [31:0] cq[$];
  sb_t         mon_e;
  logic [31:0] mon_c;
  bit          prev_ready = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Completion monitor: JTAG accesses end on a rising monitor_ready,
  // CPU reads end when waitrequest drops with cpu_read held.
  always @(negedge clk) begin
    if (reset_n) begin
      if (!prev_ready && monitor_ready) begin
        if (jq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL jtag_unexpected_done: got completion expected none");
        end else begin
          mon_e = jq.pop_front();
          if (mon_e.chk) chk("jtag_mondreg", MonDReg, mon_e.d);
        end
      end
      if (cpu_read && !cpu_waitrequest) begin
        if (cq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL cpu_unexpected_done: got completion expected none");
        end else begin
          mon_c = cq.pop_front();
          chk("cpu_readdata", cpu_readdata, mon_c);
        end
      end
    end
    prev_ready = monitor_ready;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (3) step();
  endtask

  task automatic pulse(input bit a, input bit b, input logic [1:0] cmd,
                       input logic [31:0] pay, input bit dack);
    step();
    take_action_ocimem_a = a;
    take_action_ocimem_b = b;
    jdo                  = {cmd, 4'h0, pay};
    debugack             = dack;
    step();
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    debugack             = 1'b1;
  endtask

  task automatic cpu_wait(output int stalls);
    int n;
    n = 0;
    do begin
      step();
      take_action_ocimem_a = 1'b0;
      n++;
    end while (cpu_waitrequest && n < 10);
    if (cpu_waitrequest) begin
      n_tests++; n_fail++;
      $display("FAIL cpu_timeout: got waitrequest=1 expected 0 within 10 cycles");
    end
    stalls = n - 1;
  endtask

  typedef struct {
    bit          a;
    bit          b;
    logic [1:0]  cmd;
    logic [31:0] pay;
    bit          dack;
    int          sb;    // 0 none, 1 read with data check, 2 accepted write
    logic [31:0] md;
    bit          err;
  } vec_t;

  vec_t vt [20];

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | i;
    ram_rdata            = 32'h0;
    reset_n              = 1'b0;
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    jdo                  = '0;
    debugack             = 1'b1;
    cpu_address          = '0;
    cpu_read             = 1'b0;
    cpu_write            = 1'b0;
    cpu_writedata        = 32'h0;
    cpu_byteenable       = 4'h0;

    //            a  b  cmd    pay            dk sb  md             err
    vt[0]  = '{1, 0, 2'b00, 32'h0000_0010, 1, 0, 32'h0,         0};
    vt[1]  = '{0, 1, 2'b00, 32'hDEAD_BEEF, 1, 2, 32'h0,         0};
    vt[2]  = '{0, 1, 2'b00, 32'h1234_5678, 1, 2, 32'h0,         0};
    vt[3]  = '{1, 0, 2'b00, 32'h0000_0010, 1, 0, 32'h0,         0};
    vt[4]  = '{1, 0, 2'b01, 32'h0,         1, 1, 32'hDEAD_BEEF, 0};
    vt[5]  = '{1, 0, 2'b10, 32'h0,         1, 1, 32'h1234_5678, 0};
    vt[6]  = '{1, 0, 2'b10, 32'h0,         1, 1, 32'h1234_5678, 0};
    vt[7]  = '{1, 0, 2'b01, 32'h0,         1, 1, 32'h1234_5678, 0};
    vt[8]  = '{1, 0, 2'b00, 32'h0000_00FF, 1, 0, 32'h0,         0};
    vt[9]  = '{0, 1, 2'b00, 32'hCAFE_F00D, 1, 2, 32'h0,         0};
    vt[10] = '{1, 0, 2'b01, 32'h0,         1, 1, 32'hA500_0000, 0};
    vt[11] = '{1, 0, 2'b00, 32'h0000_00FF, 1, 0, 32'h0,         0};
    vt[12] = '{1, 0, 2'b01, 32'h0,         1, 1, 32'hCAFE_F00D, 0};
    vt[13] = '{1, 0, 2'b10, 32'h0,         1, 1, 32'hA500_0000, 0};
    vt[14] = '{0, 1, 2'b00, 32'h1111_1111, 0, 0, 32'h0,         1};
    vt[15] = '{1, 0, 2'b10, 32'h0,         1, 1, 32'hA500_0000, 1};
    vt[16] = '{1, 0, 2'b11, 32'h0,         1, 0, 32'h0,         0};
    vt[17] = '{1, 1, 2'b01, 32'h7777_7777, 1, 1, 32'hA500_0000, 1};
    vt[18] = '{1, 0, 2'b11, 32'h0,         1, 0, 32'h0,         0};
    vt[19] = '{1, 0, 2'b10, 32'h0,         1, 1, 32'hA500_0001, 0};

    // ---------------- reset values ----------------
    step(); step();
    chk("rst_ready",     {31'h0, monitor_ready},   32'h1);
    chk("rst_error",     {31'h0, monitor_error},   32'h0);
    chk("rst_mondreg",   MonDReg,                  32'h0);
    chk("rst_readdata",  cpu_readdata,             32'h0);
    chk("rst_wren",      {31'h0, ram_wren},        32'h0);
    reset_n = 1'b1;
    step();

    // ---------------- JTAG vector table ----------------
    for (int i = 0; i < 20; i++) begin
      pulse(vt[i].a, vt[i].b, vt[i].cmd, vt[i].pay, vt[i].dack);
      if (vt[i].sb == 1) jq.push_back('{1'b1, vt[i].md});
      if (vt[i].sb == 2) jq.push_back('{1'b0, 32'h0});
      settle();
      chk($sformatf("vec%0d_error", i), {31'h0, monitor_error}, {31'h0, vt[i].err});
      chk($sformatf("vec%0d_ready", i), {31'h0, monitor_ready}, 32'h1);
    end
    chk("ram_jtag_write", mem[8'h10], 32'hDEAD_BEEF);
    chk("ram_wrap_write", mem[8'hFF], 32'hCAFE_F00D);
    chk("ram_dropped_wr", mem[8'h00], 32'hA500_0000);

    // ---------------- JTAG read latency ----------------
    pulse(1, 0, 2'b00, 32'h10, 1);
    settle();
    pulse(1, 0, 2'b01, 32'h0, 1);
    jq.push_back('{1'b1, 32'hDEAD_BEEF});
    chk("lat_ready_t1", {31'h0, monitor_ready}, 32'h0);
    step();
    chk("lat_ready_t2", {31'h0, monitor_ready}, 32'h0);
    step();
    chk("lat_ready_t3", {31'h0, monitor_ready}, 32'h1);
    chk("lat_mondreg_t3", MonDReg, 32'hDEAD_BEEF);
    settle();

    // ---------------- pulse while slot full ----------------
    pulse(1, 0, 2'b00, 32'h20, 1);
    settle();
    step();
    take_action_ocimem_a = 1'b1;
    jdo = {2'b01, 4'h0, 32'h0};
    jq.push_back('{1'b1, 32'hA500_0020});
    step();
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b1;
    jdo = {2'b00, 4'h0, 32'h9999_9999};
    step();
    take_action_ocimem_b = 1'b0;
    settle();
    chk("slotfull_error", {31'h0, monitor_error}, 32'h1);
    chk("slotfull_ram20", mem[8'h20], 32'hA500_0020);
    chk("slotfull_ram21", mem[8'h21], 32'hA500_0021);
    pulse(1, 0, 2'b11, 32'h0, 1);
    settle();
    chk("slotfull_clear", {31'h0, monitor_error}, 32'h0);

    // ---------------- CPU write (byte enables) then read ----------------
    step();
    cpu_write      = 1'b1;
    cpu_address    = 8'h40;
    cpu_writedata  = 32'h0000_BEEF;
    cpu_byteenable = 4'b0011;
    #1;
    chk("cpu_wr_wait", {31'h0, cpu_waitrequest}, 32'h0);
    chk("cpu_wr_wren", {31'h0, ram_wren},        32'h1);
    step();
    cpu_write = 1'b0;
    chk("cpu_wr_ram", mem[8'h40], 32'hA500_BEEF);
    cpu_read = 1'b1;
    cq.push_back(32'hA500_BEEF);
    cpu_wait(s);
    chk("cpu_rd_stall", s, 0);
    cpu_read = 1'b0;
    settle();

    // ---------------- contention after reset (last_grant = CPU) ----------
    step();
    reset_n = 1'b0;
    step(); step();
    reset_n = 1'b1;
    step();
    step();
    take_action_ocimem_a = 1'b1;
    jdo = {2'b01, 4'h0, 32'h0};
    jq.push_back('{1'b1, 32'hA500_0000});
    step();
    take_action_ocimem_a = 1'b0;
    cpu_read    = 1'b1;
    cpu_address = 8'h30;
    cq.push_back(32'hA500_0030);
    cpu_wait(s);
    chk("arb_stall_1", s, 2);
    chk("arb_jtag_first", jq.size(), 0);
    take_action_ocimem_a = 1'b1;
    jdo = {2'b01, 4'h0, 32'h0};
    jq.push_back('{1'b1, 32'hA500_0001});
    cpu_address = 8'h31;
    cq.push_back(32'hA500_0031);
    cpu_wait(s);
    chk("arb_stall_2", s, 3);
    chk("arb_jtag_again", jq.size(), 0);
    cpu_address = 8'h32;
    cq.push_back(32'hA500_0032);
    cpu_wait(s);
    chk("arb_stall_3", s, 1);
    cpu_read = 1'b0;
    settle();

    // ---------------- reset asserted during J_RD ----------------
    pulse(0, 1, 2'b00, 32'h0, 0);
    settle();
    chk("pre_rst_error", {31'h0, monitor_error}, 32'h1);
    step();
    take_action_ocimem_a = 1'b1;
    jdo = {2'b01, 4'h0, 32'h0};
    step();
    take_action_ocimem_a = 1'b0;
    step();
    reset_n        = 1'b0;
    cpu_write      = 1'b1;
    cpu_address    = 8'h50;
    cpu_writedata  = 32'h0;
    cpu_byteenable = 4'hF;
    #1;
    chk("midrst_ready",    {31'h0, monitor_ready}, 32'h1);
    chk("midrst_error",    {31'h0, monitor_error}, 32'h0);
    chk("midrst_mondreg",  MonDReg,                32'h0);
    chk("midrst_readdata", cpu_readdata,           32'h0);
    chk("midrst_wren",     {31'h0, ram_wren},      32'h0);
    step(); step();
    chk("midrst_no_write", mem[8'h50], 32'hA500_0050);
    cpu_write = 1'b0;
    reset_n   = 1'b1;
    step();
    pulse(1, 0, 2'b00, 32'h10, 1);
    settle();
    pulse(1, 0, 2'b01, 32'h0, 1);
    jq.push_back('{1'b1, 32'hDEAD_BEEF});
    settle();
    chk("postrst_ready", {31'h0, monitor_ready}, 32'h1);
    chk("postrst_mondreg", MonDReg, 32'hDEAD_BEEF);

    chk("sb_jtag_empty", jq.size(), 0);
    chk("sb_cpu_empty",  cq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
